// File: rtl/key_event_ctrl.sv
// N-channel push-button front end: synchronise, debounce and decode each key into
// press / release / short / long / auto-repeat pulses. All channels are independent.
module key_event_ctrl #(
  parameter int N_KEYS        = 4,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int DEB_CYCLES    = 240000,
  parameter int LONG_CYCLES   = 12000000,
  parameter int REPEAT_CYCLES = 2400000,
  parameter int CNT_W         = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_key,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_short,
  output logic [N_KEYS-1:0] o_long,
  output logic [N_KEYS-1:0] o_repeat
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam bit               REP_EN    = (REPEAT_CYCLES != 0);

  logic [N_KEYS-1:0] sync1_r;
  logic [N_KEYS-1:0] sync2_r;
  logic [N_KEYS-1:0] sample_s;

  // Two-flop synchroniser; reset loads the released pin level so no phantom press appears
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_r <= {N_KEYS{ACTIVE_LOW}};
      sync2_r <= {N_KEYS{ACTIVE_LOW}};
    end else begin
      sync1_r <= i_key;
      sync2_r <= sync1_r;
    end
  end

  assign sample_s = sync2_r ^ {N_KEYS{ACTIVE_LOW}};

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    logic [CNT_W-1:0] dcnt_r, dcnt_s, hcnt_r, hcnt_s, rcnt_r, rcnt_s;
    logic             level_r, level_s, rise_s, fall_s;
    state_t           state_r, state_s;
    logic             press_r, release_r, short_r, long_r, repeat_r;
    logic             press_s, release_s, short_s, long_s, repeat_s;

    // Debounce: count consecutive samples disagreeing with the accepted level
    always_comb begin
      dcnt_s  = '0;
      level_s = level_r;
      rise_s  = 1'b0;
      fall_s  = 1'b0;
      if (sample_s[g] == level_r) begin
        dcnt_s = '0;
      end else if (dcnt_r == DEB_LAST) begin
        level_s = ~level_r;
        rise_s  = ~level_r;
        fall_s  = level_r;
        dcnt_s  = '0;
      end else begin
        dcnt_s = dcnt_r + CNT_ONE;
      end
    end

    // Hold FSM; a release takes precedence over a long/repeat expiry in the same cycle
    always_comb begin
      state_s   = state_r;
      hcnt_s    = hcnt_r;
      rcnt_s    = rcnt_r;
      press_s   = 1'b0;
      release_s = 1'b0;
      short_s   = 1'b0;
      long_s    = 1'b0;
      repeat_s  = 1'b0;
      case (state_r)
        ST_IDLE: begin
          hcnt_s = '0;
          rcnt_s = '0;
          if (rise_s) begin
            state_s = ST_HELD;
            press_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (fall_s) begin
            state_s   = ST_IDLE;
            release_s = 1'b1;
            short_s   = 1'b1;
            hcnt_s    = '0;
          end else if (hcnt_r == LONG_LAST) begin
            state_s = ST_LONG;
            long_s  = 1'b1;
            hcnt_s  = '0;
            rcnt_s  = '0;
          end else begin
            hcnt_s = hcnt_r + CNT_ONE;
          end
        end
        ST_LONG: begin
          if (fall_s) begin
            state_s   = ST_IDLE;
            release_s = 1'b1;
            rcnt_s    = '0;
          end else if (!REP_EN) begin
            rcnt_s = '0;
          end else if (rcnt_r == REP_LAST) begin
            repeat_s = 1'b1;
            rcnt_s   = '0;
          end else begin
            rcnt_s = rcnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          hcnt_s  = '0;
          rcnt_s  = '0;
        end
      endcase
    end

    // Channel state and registered outputs
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        dcnt_r    <= '0;
        hcnt_r    <= '0;
        rcnt_r    <= '0;
        level_r   <= 1'b0;
        state_r   <= ST_IDLE;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        short_r   <= 1'b0;
        long_r    <= 1'b0;
        repeat_r  <= 1'b0;
      end else begin
        dcnt_r    <= dcnt_s;
        hcnt_r    <= hcnt_s;
        rcnt_r    <= rcnt_s;
        level_r   <= level_s;
        state_r   <= state_s;
        press_r   <= press_s;
        release_r <= release_s;
        short_r   <= short_s;
        long_r    <= long_s;
        repeat_r  <= repeat_s;
      end
    end

    assign o_level[g]   = level_r;
    assign o_press[g]   = press_r;
    assign o_release[g] = release_r;
    assign o_short[g]   = short_r;
    assign o_long[g]    = long_r;
    assign o_repeat[g]  = repeat_r;
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Scoreboard bench for key_event_ctrl: two instances (repeat enabled / disabled) share
// stimulus; a behavioural model predicts every cycle's outputs, a monitor compares them.
module tb_key_event_ctrl;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int LNG = 20;

  typedef struct packed {
    logic [N-1:0] level, press, rel, shrt, lng, rpt;
  } out_t;

  typedef struct packed {
    out_t a;
    out_t b;
  } exp_t;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [N-1:0] i_key = 4'hF;
  logic [N-1:0] a_level, a_press, a_release, a_short, a_long, a_repeat;
  logic [N-1:0] b_level, b_press, b_release, b_short, b_long, b_repeat;

  always #5 clk = ~clk;

  key_event_ctrl #(.N_KEYS(N), .ACTIVE_LOW(1'b1), .DEB_CYCLES(DEB), .LONG_CYCLES(LNG),
                   .REPEAT_CYCLES(8), .CNT_W(8)) dut_a (
    .i_clk(clk), .i_rst(i_rst), .i_key(i_key),
    .o_level(a_level), .o_press(a_press), .o_release(a_release),
    .o_short(a_short), .o_long(a_long), .o_repeat(a_repeat));

  key_event_ctrl #(.N_KEYS(N), .ACTIVE_LOW(1'b1), .DEB_CYCLES(DEB), .LONG_CYCLES(LNG),
                   .REPEAT_CYCLES(0), .CNT_W(8)) dut_b (
    .i_clk(clk), .i_rst(i_rst), .i_key(i_key),
    .o_level(b_level), .o_press(b_press), .o_release(b_release),
    .o_short(b_short), .o_long(b_long), .o_repeat(b_repeat));

  // Behavioural model state, indexed [instance][channel]
  bit pipe0 [2][N];
  bit pipe1 [2][N];
  bit lvl   [2][N];
  bit holding [2][N];
  bit long_done [2][N];
  int run   [2][N];
  int age   [2][N];
  int since [2][N];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic model_step(input logic [N-1:0] key, input logic rst);
    out_t e [2];
    exp_t x;
    for (int inst = 0; inst < 2; inst++) begin
      int rep;
      rep = (inst == 0) ? 8 : 0;
      e[inst] = '0;
      for (int ch = 0; ch < N; ch++) begin
        bit s, rise, fall;
        if (rst) begin
          pipe0[inst][ch] = 1'b0; pipe1[inst][ch] = 1'b0; lvl[inst][ch] = 1'b0;
          holding[inst][ch] = 1'b0; long_done[inst][ch] = 1'b0;
          run[inst][ch] = 0; age[inst][ch] = 0; since[inst][ch] = 0;
        end else begin
          s = pipe1[inst][ch];
          pipe1[inst][ch] = pipe0[inst][ch];
          pipe0[inst][ch] = (key[ch] == 1'b0);
          rise = 1'b0;
          fall = 1'b0;
          if (s == lvl[inst][ch]) begin
            run[inst][ch] = 0;
          end else begin
            run[inst][ch]++;
            if (run[inst][ch] == DEB) begin
              lvl[inst][ch] = !lvl[inst][ch];
              run[inst][ch] = 0;
              rise = lvl[inst][ch];
              fall = !lvl[inst][ch];
            end
          end
          if (rise) begin
            holding[inst][ch] = 1'b1; long_done[inst][ch] = 1'b0;
            age[inst][ch] = 0; since[inst][ch] = 0;
            e[inst].press[ch] = 1'b1;
          end else if (fall) begin
            e[inst].rel[ch]  = 1'b1;
            e[inst].shrt[ch] = !long_done[inst][ch];
            holding[inst][ch] = 1'b0;
          end else if (holding[inst][ch]) begin
            if (!long_done[inst][ch]) begin
              age[inst][ch]++;
              if (age[inst][ch] == LNG) begin
                long_done[inst][ch] = 1'b1;
                since[inst][ch] = 0;
                e[inst].lng[ch] = 1'b1;
              end
            end else if (rep != 0) begin
              since[inst][ch]++;
              if (since[inst][ch] == rep) begin
                since[inst][ch] = 0;
                e[inst].rpt[ch] = 1'b1;
              end
            end
          end
        end
        e[inst].level[ch] = lvl[inst][ch];
      end
    end
    x.a = e[0];
    x.b = e[1];
    exp_q.push_back(x);
  endtask

  task automatic step(input logic [N-1:0] key, input logic rst);
    @(negedge clk);
    i_key = key;
    i_rst = rst;
    @(posedge clk);
    model_step(key, rst);
  endtask

  task automatic run_for(input logic [N-1:0] key, input logic rst, input int n);
    for (int i = 0; i < n; i++) step(key, rst);
  endtask

  // Monitor: every cycle the DUTs present a full output set, compared against the queue head
  always @(negedge clk) begin
    exp_t e;
    out_t act_a, act_b;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc++;
      act_a = {a_level, a_press, a_release, a_short, a_long, a_repeat};
      act_b = {b_level, b_press, b_release, b_short, b_long, b_repeat};
      n_checks++;
      if (act_a !== e.a) begin
        n_fail++;
        $display("FAIL outputs_rep8 cycle=%0d actual=%h expected=%h", cyc, act_a, e.a);
      end
      n_checks++;
      if (act_b !== e.b) begin
        n_fail++;
        $display("FAIL outputs_rep0 cycle=%0d actual=%h expected=%h", cyc, act_b, e.b);
      end
    end
  end

  initial begin
    logic [N-1:0] key;
    int           left [N];
    run_for(4'hF, 1'b1, 3);
    run_for(4'hF, 1'b0, 100);
    // clean short press on key0
    run_for(4'hE, 1'b0, 10);
    run_for(4'hF, 1'b0, 25);
    // bouncing key1, then a too-short glitch
    for (int i = 0; i < 5; i++) begin
      run_for(4'hD, 1'b0, 2);
      run_for(4'hF, 1'b0, 2);
    end
    run_for(4'hF, 1'b0, 20);
    run_for(4'hD, 1'b0, 3);
    run_for(4'hF, 1'b0, 20);
    // long hold with repeats on key2
    run_for(4'hB, 1'b0, 60);
    run_for(4'hF, 1'b0, 20);
    // key3: release resolves on the long-expiry cycle, then a plain long hold
    run_for(4'h7, 1'b0, 20);
    run_for(4'hF, 1'b0, 20);
    run_for(4'h7, 1'b0, 40);
    run_for(4'hF, 1'b0, 20);
    // reset in the middle of a key0 hold
    run_for(4'hE, 1'b0, 15);
    run_for(4'hE, 1'b1, 1);
    run_for(4'hE, 1'b0, 20);
    run_for(4'hF, 1'b0, 20);
    // randomized per-channel hold/bounce durations with occasional resets
    key = 4'hF;
    for (int ch = 0; ch < N; ch++) left[ch] = $urandom_range(1, 30);
    for (int c = 0; c < 1500; c++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (left[ch] == 0) begin
          key[ch] = ~key[ch];
          left[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 60);
        end else begin
          left[ch]--;
        end
      end
      step(key, ($urandom_range(0, 399) == 0));
    end
    run_for(4'hF, 1'b0, 40);
    @(negedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
